// File: rtl/mac_accumulator.sv
// Frame-based multiply-accumulate wrapper around an external pipelined multiplier.
// Operand pairs are registered onto the multiplier and their products are summed LAT cycles later.
module mac_accumulator #(
  parameter int WIDTH = 8,
  parameter int LAT   = 3,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 ovf
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [7:0]         r_len;
  logic [7:0]         r_issued;
  logic [LAT-1:0]     r_vpipe;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_mulA;
  logic [WIDTH-1:0]   r_mulB;

  logic               w_accept;
  logic               w_lastBeat;
  logic               w_accum;
  logic [ACC_W:0]     w_prodExt;
  logic [ACC_W:0]     w_sum;

  assign w_accept   = in_valid && (r_state == ISSUE);
  assign w_lastBeat = w_accept && ((r_issued + 8'd1) == r_len);
  assign w_accum    = r_vpipe[LAT-1];
  // One extra bit on the sum exposes the carry that sets the sticky overflow flag.
  assign w_prodExt  = {{(ACC_W + 1 - 2*WIDTH){1'b0}}, mul_prod};
  assign w_sum      = {1'b0, r_acc} + w_prodExt;

  assign busy      = (r_state != IDLE);
  assign in_ready  = (r_state == ISSUE);
  assign out_valid = (r_state == DONE);
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;
  assign mul_a     = r_mulA;
  assign mul_b     = r_mulB;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = (len == 8'd0) ? DONE : ISSUE;
      ISSUE:   if (w_lastBeat) w_nextState = DRAIN;
      DRAIN:   if (r_vpipe == '0) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_vpipe  <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_mulA   <= '0;
      r_mulB   <= '0;
    end else begin
      r_state <= w_nextState;
      r_vpipe <= {r_vpipe[LAT-2:0], w_accept};
      if (w_accept) begin
        r_mulA   <= in_a;
        r_mulB   <= in_b;
        r_issued <= r_issued + 8'd1;
      end
      // A new frame wins over accumulation; the pipe is always empty in IDLE anyway.
      if ((r_state == IDLE) && start) begin
        r_acc    <= '0;
        r_ovf    <= 1'b0;
        r_len    <= len;
        r_issued <= '0;
      end else if (w_accum) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (w_sum[ACC_W]) r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: two accumulator widths share one stimulus stream, each fed by its own
// behavioural LAT-cycle multiplier model.
module tb_mac_accumulator;

  localparam int WIDTH = 8;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       len;
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_ready;

  logic             busy, in_ready, out_valid, ovf;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [15:0]      mul_prod;
  logic [23:0]      acc_out;

  logic             busy16, in_ready16, out_valid16, ovf16;
  logic [WIDTH-1:0] mul_a16, mul_b16;
  logic [15:0]      mul_prod16;
  logic [15:0]      acc_out16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(WIDTH), .LAT(LAT), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  mac_accumulator #(.WIDTH(WIDTH), .LAT(LAT), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_prod(mul_prod16),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16), .ovf(ovf16)
  );

  // Multiplier models: product of the registered operands appears LAT edges later.
  logic [15:0] p1, p2, q1, q2;
  always @(posedge clk) begin
    p1 <= mul_a * mul_b;
    p2 <= p1;
    q1 <= mul_a16 * mul_b16;
    q2 <= q1;
  end
  assign mul_prod   = p2;
  assign mul_prod16 = q2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic sendPair(input logic [7:0] a, input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("[TB] FAIL sendPair_timeout in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic waitDone;
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL waitDone_timeout out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic acceptResult;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL accept_to_idle busy=%0b out_valid=%0b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags busy=%0b in_ready=%0b out_valid=%0b ovf=%0b required 0000",
               busy, in_ready, out_valid, ovf);
    end
    checks++;
    if (acc_out !== 24'd0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_data acc=%0d mul_a=%0d mul_b=%0d required 0 0 0", acc_out, mul_a, mul_b);
    end
  endtask

  task automatic test_back_to_back;
    startFrame(8'd3);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_issue in_ready=%0b busy=%0b required 1 1", in_ready, busy);
    end
    in_valid = 1'b1;
    in_a = 8'd3;   in_b = 8'd4;   tick();
    in_a = 8'd5;   in_b = 8'd6;   tick();
    in_a = 8'd255; in_b = 8'd255; tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || mul_a !== 8'd255 || mul_b !== 8'd255) begin
      failures++;
      $display("[TB] FAIL b2b_drain in_ready=%0b mul_a=%0d mul_b=%0d required 0 255 255",
               in_ready, mul_a, mul_b);
    end
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      checks++;
      if (out_valid !== (i == LAT + 1)) begin
        failures++;
        $display("[TB] FAIL b2b_latency cycle=%0d out_valid=%0b required %0b", i, out_valid, (i == LAT + 1));
      end
    end
    checks++;
    if (acc_out !== 24'd65067 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_result acc=%0d ovf=%0b required 65067 0", acc_out, ovf);
    end
    acceptResult();
  endtask

  task automatic test_gapped;
    logic busyDropped;
    busyDropped = 1'b0;
    startFrame(8'd4);
    for (int i = 1; i <= 4; i++) begin
      sendPair(i[7:0], i[7:0], 0);
      if (!busy) busyDropped = 1'b1;
      tick();
      if (!busy) busyDropped = 1'b1;
      tick();
      if (!busy) busyDropped = 1'b1;
    end
    waitDone();
    checks++;
    if (busyDropped !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gapped_busy dropped=%0b required 0", busyDropped);
    end
    checks++;
    if (acc_out !== 24'd30) begin
      failures++;
      $display("[TB] FAIL gapped_result acc=%0d required 30", acc_out);
    end
    acceptResult();
  endtask

  task automatic test_empty;
    startFrame(8'd0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 24'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_frame out_valid=%0b acc=%0d in_ready=%0b required 1 0 0",
               out_valid, acc_out, in_ready);
    end
    acceptResult();
  endtask

  task automatic test_overflow;
    startFrame(8'd2);
    sendPair(8'd255, 8'd255, 0);
    sendPair(8'd255, 8'd255, 0);
    waitDone();
    checks++;
    if (acc_out16 !== 16'd64514 || ovf16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf16_result acc=%0d ovf=%0b required 64514 1", acc_out16, ovf16);
    end
    checks++;
    if (acc_out !== 24'd130050 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf24_result acc=%0d ovf=%0b required 130050 0", acc_out, ovf);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1 || i == 3);
      len   = 8'd1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || acc_out16 !== 16'd64514 || ovf16 !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold cycle=%0d out_valid=%0b acc=%0d ovf=%0b in_ready=%0b required 1 64514 1 0",
                 i, out_valid, acc_out16, ovf16, in_ready);
      end
    end
    start = 1'b0;
    len   = 8'd0;
    acceptResult();
  endtask

  task automatic test_ovf_clear;
    startFrame(8'd1);
    checks++;
    if (ovf16 !== 1'b0 || acc_out16 !== 16'd0 || in_ready16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_clear ovf=%0b acc=%0d in_ready=%0b required 0 0 1", ovf16, acc_out16, in_ready16);
    end
    sendPair(8'd2, 8'd3, 0);
    waitDone();
    checks++;
    if (acc_out16 !== 16'd6 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear_frame acc=%0d ovf=%0b required 6 0", acc_out16, ovf16);
    end
    acceptResult();
  endtask

  task automatic test_reset_midframe;
    logic accMoved;
    accMoved = 1'b0;
    startFrame(8'd5);
    sendPair(8'd100, 8'd100, 0);
    sendPair(8'd200, 8'd200, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc_out !== 24'd0 || mul_a !== 8'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_state busy=%0b acc=%0d mul_a=%0d in_ready=%0b required 0 0 0 0",
               busy, acc_out, mul_a, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (acc_out !== 24'd0) accMoved = 1'b1;
    end
    checks++;
    if (accMoved !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_stale acc_moved=%0b required 0", accMoved);
    end
    startFrame(8'd1);
    sendPair(8'd7, 8'd9, 0);
    waitDone();
    checks++;
    if (acc_out !== 24'd63 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_result acc=%0d ovf=%0b required 63 0", acc_out, ovf);
    end
    acceptResult();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_empty();
    test_overflow();
    test_backpressure();
    test_ovf_clear();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
